fetch_buffer: RTL
=================

// Module: fetch_buffer
// PURPOSE
//  Instruction fetch queue between the program counter register and the decode stage.
//  Captures {pc, instr} pairs from fetch and presents them to decode under a valid/ready handshake.
//  Drives the PC write-enable as backpressure, so the PC advances only when a fetch is accepted.
//  Drops all queued entries on a control-flow redirect (flush).
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >= 2
//  XLEN   32  width of PC and instruction
// PORTS
//  i_clk         in   1     clock
//  i_reset       in   1     reset: synchronous, active-high
//  i_fetch_valid in   1     i_pc/i_instr hold a fetched instruction this cycle
//  i_pc          in   XLEN  PC of the fetched instruction (PC register output)
//  i_instr       in   XLEN  instruction word from instruction memory
//  o_pc_enable   out  1     PC write-enable; 1 = fetch accepted or redirect, PC may load next value
//  i_flush       in   1     redirect from execute; discard all queued and incoming entries
//  o_valid       out  1     decode-side entry valid
//  o_pc          out  XLEN  PC of head entry
//  o_pc_plus4    out  XLEN  o_pc + 4, modulo 2^XLEN
//  o_instr       out  XLEN  head instruction; NOP 0x0000_0013 when o_valid=0
//  i_id_ready    in   1     decode consumes head this cycle when o_valid=1
// BEHAVIOUR
//  - Storage: circular buffer, DEPTH entries, wr_ptr/rd_ptr of log2(DEPTH) bits (natural wrap), count 0..DEPTH.
//  - push = i_fetch_valid & (count<DEPTH | pop) & ~i_flush;  pop = o_valid & i_id_ready & ~i_flush.
//  - Full with simultaneous pop: push accepted; count unchanged; both pointers advance.
//  - Empty with push (no bypass): entry written; o_valid=1 next cycle. Latency 1 cycle.
//  - o_pc_enable = i_flush | (count<DEPTH) | (o_valid & i_id_ready). Combinational path i_id_ready -> o_pc_enable is intended.
//  - i_flush=1: next cycle count=0, rd_ptr=wr_ptr=0, o_valid=0.
//    Same-cycle push and pop are suppressed; the PC loads the redirect target.
//  - i_flush has priority over push/pop; i_reset has priority over everything.
//  - Reset values: count=0, pointers=0, o_valid=0, o_pc=0, o_pc_plus4=4, o_instr=NOP.
//    Storage contents need no reset.
//  - Outputs o_pc/o_instr/o_pc_plus4 derive from the head entry. When o_valid=0: o_pc=0, o_pc_plus4=4.
//  - Entries drain strictly in FIFO order; no reordering or duplication.
//  - Reset mid-operation: all queued entries lost; first post-reset push appears at o_* one cycle later.
// CONFIGURATION
//  FETCH_BUF_BYPASS_EN defined:
//    - count==0 & i_fetch_valid & i_id_ready & ~i_flush: fetch data drives o_* combinationally,
//      o_valid=1 in the same cycle, and the entry is not written (zero-latency pass-through).
//    - count==0 & i_fetch_valid & ~i_id_ready: entry written as normal.
//  FETCH_BUF_BYPASS_EN undefined:
//    - always registered; minimum fetch-to-decode latency 1 cycle.
//  Handshake, flush and reset rules are identical in both builds.
// STRUCTURE
//  Package fetch_pkg:
//    - localparam NOP_INSTR = 32'h0000_0013
//    - typedef struct packed {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} fetch_entry_t
//  Single module; storage is an fetch_entry_t array inline.
//  No sub-module: pointer/count control is too small to justify one.
// TESTING
//  1 Reset: assert i_reset 2 cycles -> o_valid=0, o_instr=0x13, o_pc=0, o_pc_plus4=4, o_pc_enable=1.
//  2 Stream: push pc 0x0,0x4,0x8 with i_id_ready=1 -> o_pc 0x0,0x4,0x8 on consecutive cycles.
//    Latency 1 cycle (0 if FETCH_BUF_BYPASS_EN); o_pc_plus4 = o_pc+4.
//  3 Fill: i_id_ready=0, push 5 entries -> first 4 stored, o_pc_enable=0 after the 4th.
//    Raise i_id_ready -> drain pc 0x0..0xC in order.
//  4 Full+pop: count=4, i_id_ready=1, i_fetch_valid=1 -> o_pc_enable=1, count stays 4,
//    pointer wrap verified over 10 cycles.
//  5 Flush: 3 entries queued, i_flush=1 with push pending -> next cycle o_valid=0, o_instr=0x13.
//    Next push pc 0x100 is the next output.
//  6 Reset mid-stream: reset with count=2 -> o_valid=0 next cycle, no stale entries emerge afterward.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch queue.
// XLEN is fixed here because the stored entry type is declared at package scope.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the fetch buffer.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface fetch_buffer_if;
  import fetch_pkg::*;

  logic            i_fetch_valid;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_instr;
  logic            o_pc_enable;
  logic            i_flush;
  logic            o_valid;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_pc_plus4;
  logic [XLEN-1:0] o_instr;
  logic            i_id_ready;

  modport slave (
    input  i_fetch_valid, i_pc, i_instr, i_flush, i_id_ready,
    output o_pc_enable, o_valid, o_pc, o_pc_plus4, o_instr
  );

  modport master (
    output i_fetch_valid, i_pc, i_instr, i_flush, i_id_ready,
    input  o_pc_enable, o_valid, o_pc, o_pc_plus4, o_instr
  );

endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch queue: circular buffer of {pc, instr} between the PC register and decode.
// Define FETCH_BUF_BYPASS_EN for a zero-latency pass-through when the queue is empty and decode is ready.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  fetch_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  logic            not_full;
  logic            stored_valid;
  logic            bypass;
  logic            out_valid;
  logic            pop;
  logic            push;
  logic            mem_wr;
  logic            mem_rd;
  fetch_entry_t    head;
  logic [XLEN-1:0] head_pc;

  assign not_full     = (count_q != DEPTH_C);
  assign stored_valid = (count_q != '0);

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = ~stored_valid & bus.i_fetch_valid & bus.i_id_ready & ~bus.i_flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = stored_valid | bypass;
  assign pop       = out_valid & bus.i_id_ready & ~bus.i_flush;
  assign push      = bus.i_fetch_valid & (not_full | pop) & ~bus.i_flush;
  // A bypassed fetch is pushed and popped in the same cycle, so it never touches storage.
  assign mem_wr    = push & ~bypass;
  assign mem_rd    = pop & ~bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (mem_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (mem_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({mem_wr, mem_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_wr) mem_q[wr_ptr_q] <= '{pc: bus.i_pc, instr: bus.i_instr};
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    if (bypass) head = '{pc: bus.i_pc, instr: bus.i_instr};
  end

  assign head_pc = out_valid ? head.pc : '0;

  assign bus.o_valid     = out_valid;
  assign bus.o_pc        = head_pc;
  assign bus.o_pc_plus4  = head_pc + XLEN'(4);
  assign bus.o_instr     = out_valid ? head.instr : NOP_INSTR;
  // Decode readiness feeds straight through so the PC can advance while the queue is full.
  assign bus.o_pc_enable = bus.i_flush | not_full | (out_valid & bus.i_id_ready);

endmodule
